// File: rtl/ysyx_201979054_mux_pipe_pkg.sv
// Shared types for the registered N-to-1 select stage: FSM state encoding
// and a small helper that maps a state onto the registered ready output.
package ysyx_201979054_mux_pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef enum logic [1:0] {
    EMPTY = ST_EMPTY,
    ONE   = ST_ONE,
    FULL  = ST_FULL
  } state_t;

  // Upstream may only be offered a slot while the skid register is free.
  function automatic logic ready_in(input state_t s);
    return (s != FULL);
  endfunction

endpackage

// File: rtl/ysyx_201979054_mux_nto1.sv
// Combinational N-to-1 select with out-of-range detection; an out-of-range
// index yields all-zero data so no X can propagate downstream.
module ysyx_201979054_mux_nto1 #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_INPUTS = 8,
  parameter int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic [SEL_WIDTH-1:0]             i_sel,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic                             o_oor
);

  // NOTE: every output gets a default before the loop; without it a select
  // that matches no index would leave the outputs unassigned and infer a latch.
  always_comb begin
    o_data = '0;
    o_oor  = 1'b1;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (i_sel == SEL_WIDTH'(k)) begin
        o_data = i_data[k*DATA_WIDTH +: DATA_WIDTH];
        o_oor  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ysyx_201979054_mux_pipe.sv
// Registered N-to-1 select stage with valid/ready handshake and a 2-entry
// skid buffer. Optional per-beat parity output when MUX_PIPE_PARITY_EN is defined.
module ysyx_201979054_mux_pipe
  import ysyx_201979054_mux_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_INPUTS = 8,
  parameter int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic [SEL_WIDTH-1:0]             i_sel,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data,
  output logic                             o_valid,
  input  logic                             i_ready,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic                             o_sel_err
`ifdef MUX_PIPE_PARITY_EN
  ,
  output logic                             o_parity
`endif
);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_ready;

  logic [DATA_WIDTH-1:0]   r_main_data;
  logic                    r_main_err;
  logic [DATA_WIDTH-1:0]   r_skid_data;
  logic                    r_skid_err;

  logic [DATA_WIDTH-1:0]   w_sel_data;
  logic                    w_sel_err;
  logic                    w_accept;
  logic                    w_emit;
  logic                    w_load_main;
  logic                    w_main_from_skid;
  logic                    w_load_skid;

  ysyx_201979054_mux_nto1 #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_INPUTS (NUM_INPUTS),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_mux (
    .i_sel  (i_sel),
    .i_data (i_data),
    .o_data (w_sel_data),
    .o_oor  (w_sel_err)
  );

  assign w_accept = i_valid & r_ready;
  assign w_emit   = (r_state != EMPTY) & i_ready;

  always_comb begin
    w_state_nxt      = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ONE;
          w_load_main = 1'b1;
        end
      end
      ONE: begin
        if (w_accept && w_emit) begin
          w_load_main = 1'b1;
        end else if (w_emit) begin
          w_state_nxt = EMPTY;
        end else if (w_accept) begin
          w_state_nxt = FULL;
          w_load_skid = 1'b1;
        end
      end
      FULL: begin
        // Ready is low here, so i_valid cannot produce an accept.
        if (w_emit) begin
          w_state_nxt      = ONE;
          w_main_from_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = EMPTY;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= EMPTY;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= ready_in(w_state_nxt);
    end
  end

  // NOTE: the data-path registers are reset as well, because o_data must read
  // zero after reset and dropped beats must not resurface from the skid.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_main_data <= '0;
      r_main_err  <= 1'b0;
      r_skid_data <= '0;
      r_skid_err  <= 1'b0;
    end else begin
      if (w_load_main) begin
        r_main_data <= w_sel_data;
        r_main_err  <= w_sel_err;
      end else if (w_main_from_skid) begin
        r_main_data <= r_skid_data;
        r_main_err  <= r_skid_err;
      end
      if (w_load_skid) begin
        r_skid_data <= w_sel_data;
        r_skid_err  <= w_sel_err;
      end
    end
  end

`ifdef MUX_PIPE_PARITY_EN
  logic r_main_par;
  logic r_skid_par;
  logic w_sel_par;

  // Out-of-range beats carry zero data, hence zero parity.
  assign w_sel_par = ^w_sel_data;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_main_par <= 1'b0;
      r_skid_par <= 1'b0;
    end else begin
      if (w_load_main) begin
        r_main_par <= w_sel_par;
      end else if (w_main_from_skid) begin
        r_main_par <= r_skid_par;
      end
      if (w_load_skid) begin
        r_skid_par <= w_sel_par;
      end
    end
  end

  assign o_parity = r_main_par;
`endif

  assign o_ready   = r_ready;
  assign o_valid   = (r_state != EMPTY);
  assign o_data    = r_main_data;
  assign o_sel_err = r_main_err;

endmodule
